// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus: grants one execution-unit result
// per cycle and broadcasts it through a single register stage.
module cdb_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ROB_ID_W = 4,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned SRC_W    = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy,
  input  logic                         flush,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*ROB_ID_W-1:0]  req_rob_id,
  input  logic [NUM_REQ*DATA_W-1:0]    req_value,
  input  logic [NUM_REQ*DATA_W-1:0]    req_next_pc,
  output logic                         cdb_valid,
  output logic [ROB_ID_W-1:0]          cdb_rob_id,
  output logic [DATA_W-1:0]            cdb_value,
  output logic [DATA_W-1:0]            cdb_next_pc,
  output logic [SRC_W-1:0]             cdb_src,
  output logic                         err_tag0
);

  logic [SRC_W-1:0]    ptr;
  logic [SRC_W-1:0]    win;
  logic [SRC_W-1:0]    idx;
  logic                found;
  logic                grant;
  logic [ROB_ID_W-1:0] win_rob_id;
  logic [DATA_W-1:0]   win_value;
  logic [DATA_W-1:0]   win_next_pc;

  // Search from ptr upward; NUM_REQ is a power of two so SRC_W-bit addition wraps.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = ptr + SRC_W'(k);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    win_rob_id  = req_rob_id[int'(win)*ROB_ID_W +: ROB_ID_W];
    win_value   = req_value[int'(win)*DATA_W +: DATA_W];
    win_next_pc = req_next_pc[int'(win)*DATA_W +: DATA_W];
  end

  assign grant     = found && rdy && !flush && !rst;
  assign req_ready = grant ? (NUM_REQ'(1) << win) : '0;

  // Broadcast register; rdy low freezes everything including a pending pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= '0;
      cdb_valid   <= 1'b0;
      cdb_rob_id  <= '0;
      cdb_value   <= '0;
      cdb_next_pc <= '0;
      cdb_src     <= '0;
      err_tag0    <= 1'b0;
    end else if (rdy) begin
      if (flush) begin
        cdb_valid <= 1'b0;
        ptr       <= '0;
      end else if (found) begin
        ptr         <= win + SRC_W'(1);
        cdb_src     <= win;
        cdb_rob_id  <= win_rob_id;
        cdb_value   <= win_value;
        cdb_next_pc <= win_next_pc;
        // Tag 0 means "no ROB entry": consume it but never broadcast it.
        cdb_valid   <= (win_rob_id != '0);
        if (win_rob_id == '0) begin
          err_tag0 <= 1'b1;
        end
      end else begin
        cdb_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter (4 requesters, 4-bit tags, 32-bit data).
module tb_cdb_arbiter;

  localparam int unsigned NUM_REQ  = 4;
  localparam int unsigned ROB_ID_W = 4;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned SRC_W    = 2;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        rdy;
  logic                        flush;
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_REQ*ROB_ID_W-1:0] req_rob_id;
  logic [NUM_REQ*DATA_W-1:0]   req_value;
  logic [NUM_REQ*DATA_W-1:0]   req_next_pc;
  logic                        cdb_valid;
  logic [ROB_ID_W-1:0]         cdb_rob_id;
  logic [DATA_W-1:0]           cdb_value;
  logic [DATA_W-1:0]           cdb_next_pc;
  logic [SRC_W-1:0]            cdb_src;
  logic                        err_tag0;

  logic [ROB_ID_W-1:0] rid [NUM_REQ];
  logic [DATA_W-1:0]   val [NUM_REQ];
  logic [DATA_W-1:0]   npc [NUM_REQ];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_rob_id[i*ROB_ID_W +: ROB_ID_W] = rid[i];
      req_value[i*DATA_W +: DATA_W]      = val[i];
      req_next_pc[i*DATA_W +: DATA_W]    = npc[i];
    end
  end

  cdb_arbiter #(.NUM_REQ(NUM_REQ), .ROB_ID_W(ROB_ID_W), .DATA_W(DATA_W), .SRC_W(SRC_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rob_id(req_rob_id), .req_value(req_value), .req_next_pc(req_next_pc),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value),
    .cdb_next_pc(cdb_next_pc), .cdb_src(cdb_src), .err_tag0(err_tag0)
  );

  // Advance past the next rising edge; registered outputs then show that edge's result.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_payloads();
    for (int i = 0; i < NUM_REQ; i++) begin
      rid[i] = ROB_ID_W'(i + 1);
      val[i] = 32'h100 + DATA_W'(i);
      npc[i] = 32'h8000 + DATA_W'(i * 4);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; flush = 1'b0; rdy = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; req_valid = '0;
    load_payloads();
    tick(); tick();
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", cdb_valid); end
    checks++; if (cdb_rob_id !== '0) begin errors++; $display("FAIL reset_rob_id got %h exp 0", cdb_rob_id); end
    checks++; if (cdb_value !== '0 || cdb_next_pc !== '0) begin errors++; $display("FAIL reset_data got %h/%h exp 0/0", cdb_value, cdb_next_pc); end
    checks++; if (cdb_src !== '0) begin errors++; $display("FAIL reset_src got %0d exp 0", cdb_src); end
    checks++; if (err_tag0 !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err_tag0); end
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    rid[2] = 4'd5; val[2] = 32'hDEADBEEF; npc[2] = 32'h0000_1234;
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got %b exp 0100", req_ready); end
    tick();
    req_valid = '0;
    checks++; if (cdb_valid !== 1'b1 || cdb_rob_id !== 4'd5 || cdb_src !== 2'd2)
      begin errors++; $display("FAIL single_bcast got v=%b id=%0d src=%0d exp v=1 id=5 src=2", cdb_valid, cdb_rob_id, cdb_src); end
    checks++; if (cdb_value !== 32'hDEADBEEF || cdb_next_pc !== 32'h0000_1234)
      begin errors++; $display("FAIL single_data got %h/%h exp deadbeef/00001234", cdb_value, cdb_next_pc); end
    #1;
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL single_idle_ready got %b exp 0000", req_ready); end
    tick();
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL single_pulse got %b exp 0", cdb_valid); end
  endtask

  task automatic test_round_robin();
    int exp_g [5] = '{0, 1, 2, 3, 0};
    do_reset();
    load_payloads();
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (req_ready !== (4'b0001 << exp_g[k]))
        begin errors++; $display("FAIL rr_ready[%0d] got %b exp %b", k, req_ready, 4'b0001 << exp_g[k]); end
      tick();
      checks++; if (cdb_valid !== 1'b1 || cdb_src !== SRC_W'(exp_g[k]) || cdb_value !== 32'h100 + DATA_W'(exp_g[k]))
        begin errors++; $display("FAIL rr_bcast[%0d] got v=%b src=%0d val=%h exp v=1 src=%0d", k, cdb_valid, cdb_src, cdb_value, exp_g[k]); end
    end
    req_valid = '0;
  endtask

  task automatic test_skip();
    // ptr=1 after the round-robin run
    req_valid = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL skip_g1 got %b exp 0010", req_ready); end
    tick();
    req_valid = 4'b1001;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL skip_g3 got %b exp 1000", req_ready); end
    tick();
    checks++; if (cdb_src !== 2'd3 || cdb_rob_id !== 4'd4) begin errors++; $display("FAIL skip_src3 got src=%0d id=%0d exp 3/4", cdb_src, cdb_rob_id); end
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL skip_g0 got %b exp 0001", req_ready); end
    tick();
    checks++; if (cdb_src !== 2'd0 || cdb_valid !== 1'b1) begin errors++; $display("FAIL skip_src0 got src=%0d v=%b exp 0/1", cdb_src, cdb_valid); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_freeze();
    // ptr=1, cdb_valid=0, last payload from requester 0
    rdy = 1'b0; req_valid = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (req_ready !== '0) begin errors++; $display("FAIL frz_ready[%0d] got %b exp 0000", k, req_ready); end
      tick();
      checks++; if (cdb_valid !== 1'b0 || cdb_src !== 2'd0 || cdb_value !== 32'h100)
        begin errors++; $display("FAIL frz_hold[%0d] got v=%b src=%0d val=%h exp 0/0/100", k, cdb_valid, cdb_src, cdb_value); end
    end
    rdy = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL frz_resume got %b exp 0010", req_ready); end
    tick();
    req_valid = '0;
    checks++; if (cdb_valid !== 1'b1 || cdb_src !== 2'd1 || cdb_value !== 32'h101)
      begin errors++; $display("FAIL frz_bcast got v=%b src=%0d val=%h exp 1/1/101", cdb_valid, cdb_src, cdb_value); end
    rdy = 1'b0;
    tick();
    checks++; if (cdb_valid !== 1'b1) begin errors++; $display("FAIL frz_pulse_hold got %b exp 1", cdb_valid); end
    rdy = 1'b1;
    tick();
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL frz_pulse_end got %b exp 0", cdb_valid); end
  endtask

  task automatic test_flush_tag0();
    // ptr=2
    req_valid = 4'b1111;
    tick();
    checks++; if (cdb_valid !== 1'b1 || cdb_src !== 2'd2) begin errors++; $display("FAIL fl_pre got v=%b src=%0d exp 1/2", cdb_valid, cdb_src); end
    flush = 1'b1;
    #1;
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL fl_ready got %b exp 0000", req_ready); end
    tick();
    flush = 1'b0;
    checks++; if (cdb_valid !== 1'b0 || cdb_src !== 2'd2) begin errors++; $display("FAIL fl_kill got v=%b src=%0d exp 0/2", cdb_valid, cdb_src); end
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL fl_ptr0 got %b exp 0001", req_ready); end
    tick();
    req_valid = '0;
    checks++; if (cdb_src !== 2'd0 || cdb_valid !== 1'b1) begin errors++; $display("FAIL fl_g0 got src=%0d v=%b exp 0/1", cdb_src, cdb_valid); end
    // tag 0 request: consumed silently, sticky error
    rid[0] = '0; req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL t0_ready got %b exp 0001", req_ready); end
    tick();
    req_valid = 4'b0010;
    checks++; if (cdb_valid !== 1'b0 || err_tag0 !== 1'b1) begin errors++; $display("FAIL t0_bcast got v=%b err=%b exp 0/1", cdb_valid, err_tag0); end
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL t0_ptr got %b exp 0010", req_ready); end
    tick();
    req_valid = '0;
    checks++; if (cdb_valid !== 1'b1 || err_tag0 !== 1'b1) begin errors++; $display("FAIL t0_sticky got v=%b err=%b exp 1/1", cdb_valid, err_tag0); end
    do_reset();
    #1;
    checks++; if (err_tag0 !== 1'b0 || cdb_valid !== 1'b0) begin errors++; $display("FAIL t0_clear got err=%b v=%b exp 0/0", err_tag0, cdb_valid); end
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; req_valid = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_skip();
    test_freeze();
    test_flush_tag0();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
